// File: rtl/fifo_wr_arbiter_if.sv
// Handshake and status bundle between two producers, the write arbiter and a synchronous FIFO.
// The arbiter uses the slave modport; the producer/FIFO side uses the master modport.
interface fifo_wr_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                  src0_valid;
  logic [DATA_WIDTH-1:0] src0_data;
  logic                  src0_ready;
  logic                  src1_valid;
  logic [DATA_WIDTH-1:0] src1_data;
  logic                  src1_ready;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_r_en;
  logic                  fifo_w_en;
  logic [DATA_WIDTH-1:0] fifo_data_in;
  logic [1:0]            grant;
  logic [ADDR_WIDTH:0]   fifo_level;
  logic                  almost_full;

  modport slave (
    input  src0_valid, src0_data, src1_valid, src1_data,
    input  fifo_full, fifo_empty, fifo_r_en,
    output src0_ready, src1_ready, fifo_w_en, fifo_data_in,
    output grant, fifo_level, almost_full
  );

  modport master (
    output src0_valid, src0_data, src1_valid, src1_data,
    output fifo_full, fifo_empty, fifo_r_en,
    input  src0_ready, src1_ready, fifo_w_en, fifo_data_in,
    input  grant, fifo_level, almost_full
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port between two producers,
// with occupancy tracking from both FIFO sides and a registered almost-full flag.
module fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int BURST_LEN  = 4,
  parameter int AF_LEVEL   = 12
) (
  input logic              clk,
  input logic              rst,
  fifo_wr_arbiter_if.slave bus
);
  localparam int CW = $clog2(BURST_LEN + 1);
  localparam int LW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BURST_LEN - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [LW-1:0] LVL_MAX  = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_AF   = LW'(AF_LEVEL);
  localparam logic [LW-1:0] LVL_ONE  = LW'(1);
  localparam logic [LW-1:0] LVL_ZERO = LW'(0);

  typedef enum logic [1:0] {IDLE = 2'd0, G0 = 2'd1, G1 = 2'd2} state_t;

  state_t                state_r, state_s;
  logic                  ptr_r, ptr_s;
  logic [CW-1:0]         burst_cnt_r, burst_cnt_s;
  logic                  gap_r, gap_s;
  logic [1:0]            grant_r, grant_s;
  logic [LW-1:0]         level_r, level_s;
  logic                  af_r;
  logic                  cur_valid_s, oth_valid_s, w_en_s, rd_s, end_len_s;
  logic [DATA_WIDTH-1:0] cur_data_s;

  // Select the granted producer's handshake signals.
  always_comb begin
    cur_valid_s = 1'b0;
    oth_valid_s = 1'b0;
    cur_data_s  = '0;
    case (state_r)
      G0: begin
        cur_valid_s = bus.src0_valid;
        oth_valid_s = bus.src1_valid;
        cur_data_s  = bus.src0_data;
      end
      G1: begin
        cur_valid_s = bus.src1_valid;
        oth_valid_s = bus.src0_valid;
        cur_data_s  = bus.src1_data;
      end
      default: begin
        cur_valid_s = 1'b0;
        oth_valid_s = 1'b0;
        cur_data_s  = '0;
      end
    endcase
  end

  // gap_r is the one idle cycle spent re-granting the same producer after a full burst.
  assign w_en_s    = (state_r != IDLE) & ~gap_r & ~bus.fifo_full & cur_valid_s;
  assign end_len_s = w_en_s & (burst_cnt_r == CNT_LAST);
  assign rd_s      = bus.fifo_r_en & ~bus.fifo_empty;

  assign bus.fifo_w_en    = w_en_s;
  assign bus.fifo_data_in = cur_data_s;
  assign bus.src0_ready   = (state_r == G0) & ~gap_r & ~bus.fifo_full;
  assign bus.src1_ready   = (state_r == G1) & ~gap_r & ~bus.fifo_full;
  assign bus.grant        = grant_r;
  assign bus.fifo_level   = level_r;
  assign bus.almost_full  = af_r;

  // Next grant, burst count and round-robin pointer.
  always_comb begin
    state_s     = state_r;
    ptr_s       = ptr_r;
    burst_cnt_s = burst_cnt_r;
    gap_s       = 1'b0;
    case (state_r)
      IDLE: begin
        burst_cnt_s = '0;
        if (bus.src0_valid & bus.src1_valid) begin
          state_s = ptr_r ? G1 : G0;
        end else if (bus.src0_valid) begin
          state_s = G0;
        end else if (bus.src1_valid) begin
          state_s = G1;
        end else begin
          state_s = IDLE;
        end
      end
      G0, G1: begin
        if (gap_r) begin
          state_s = state_r;
        end else if (end_len_s | ~cur_valid_s) begin
          burst_cnt_s = '0;
          ptr_s       = (state_r == G0);
          if (oth_valid_s) begin
            state_s = (state_r == G0) ? G1 : G0;
          end else if (end_len_s) begin
            state_s = state_r;
            gap_s   = 1'b1;
          end else begin
            state_s = IDLE;
          end
        end else if (w_en_s) begin
          burst_cnt_s = burst_cnt_r + CNT_ONE;
        end else begin
          burst_cnt_s = burst_cnt_r;
        end
      end
      default: begin
        state_s     = IDLE;
        burst_cnt_s = '0;
      end
    endcase
  end

  // Grant encoding and saturating occupancy update.
  always_comb begin
    case (state_s)
      G0:      grant_s = 2'b01;
      G1:      grant_s = 2'b10;
      default: grant_s = 2'b00;
    endcase
    level_s = level_r;
    if (w_en_s & ~rd_s) begin
      if (level_r != LVL_MAX) begin
        level_s = level_r + LVL_ONE;
      end else begin
        level_s = level_r;
      end
    end else if (rd_s & ~w_en_s) begin
      if (level_r != LVL_ZERO) begin
        level_s = level_r - LVL_ONE;
      end else begin
        level_s = level_r;
      end
    end else begin
      level_s = level_r;
    end
  end

  // State, grant and status registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      ptr_r       <= 1'b0;
      burst_cnt_r <= '0;
      gap_r       <= 1'b0;
      grant_r     <= 2'b00;
      level_r     <= '0;
      af_r        <= 1'b0;
    end else begin
      state_r     <= state_s;
      ptr_r       <= ptr_s;
      burst_cnt_r <= burst_cnt_s;
      gap_r       <= gap_s;
      grant_r     <= grant_s;
      level_r     <= level_s;
      af_r        <= (level_s >= LVL_AF);
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized and directed bench for fifo_wr_arbiter against a cycle-level
// behavioural model of the grant rules and a queue model of the FIFO.
module tb_fifo_wr_arbiter;
  localparam int DW = 8, DEPTH = 16, AW = 4, BURST = 4, AF = 12;

  logic clk = 1'b0;
  logic rst = 1'b0;

  fifo_wr_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  fifo_wr_arbiter #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW),
                    .BURST_LEN(BURST), .AF_LEVEL(AF)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: owner 0 = none, 1 = src0, 2 = src1.
  int m_owner, m_ptr, m_words, m_level;
  bit m_gap;
  // Producer and FIFO environment.
  int p_next [2];
  int p_left [2];
  bit p_on [2];
  bit p_rand;
  bit force_full;
  int rd_mode;  // 0 none, 1 always, 2 random, 3 only alongside a write
  int fifo_q[$];
  int wr_data[$];
  int wr_gnt[$];
  int runs[$];
  int run_len;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = 0; m_ptr = 0; m_words = 0; m_level = 0; m_gap = 1'b0;
    fifo_q.delete(); wr_data.delete(); wr_gnt.delete(); runs.delete();
    run_len = 0;
  endtask

  task automatic idle_inputs();
    p_on[0] = 1'b0; p_on[1] = 1'b0; p_left[0] = 0; p_left[1] = 0;
    p_next[0] = 0; p_next[1] = 0;
    p_rand = 1'b0; force_full = 1'b0; rd_mode = 0;
    bus.src0_valid = 1'b0; bus.src1_valid = 1'b0;
    bus.src0_data = '0; bus.src1_data = '0;
    bus.fifo_full = 1'b0; bus.fifo_empty = 1'b1; bus.fifo_r_en = 1'b0;
  endtask

  task automatic check_reset_outputs();
    check("rst_grant", bus.grant, 0);
    check("rst_w_en", bus.fifo_w_en, 0);
    check("rst_level", bus.fifo_level, 0);
    check("rst_data", bus.fifo_data_in, 0);
    check("rst_rdy0", bus.src0_ready, 0);
    check("rst_rdy1", bus.src1_ready, 0);
    check("rst_af", bus.almost_full, 0);
  endtask

  task automatic drive_reset();
    @(negedge clk);
    #2 rst = 1'b0;
    #1 check_reset_outputs();
    model_reset();
    idle_inputs();
    #1 rst = 1'b1;
  endtask

  task automatic flush_runs();
    if (run_len > 0) begin
      runs.push_back(run_len);
      run_len = 0;
    end
  endtask

  // One clock: drive inputs after the falling edge, check, then advance the model
  // to what the next rising edge must produce.
  task automatic cycle();
    bit v [2];
    bit full, empty, ew, rd, rdv;
    int x, o, exp_data;
    bit by_len;
    @(negedge clk);
    for (int i = 0; i < 2; i++)
      v[i] = p_on[i] && (p_left[i] > 0) && (!p_rand || ($urandom_range(0, 3) != 0));
    full  = (fifo_q.size() >= DEPTH) || force_full;
    empty = (fifo_q.size() == 0);
    x = (m_owner > 0) ? m_owner - 1 : 0;
    o = 1 - x;
    ew = (m_owner != 0) && !m_gap && !full && v[x];
    case (rd_mode)
      1: rd = 1'b1;
      2: rd = ($urandom_range(0, 1) == 1);
      3: rd = ew;
      default: rd = 1'b0;
    endcase
    bus.src0_valid = v[0]; bus.src1_valid = v[1];
    bus.src0_data = DW'(p_next[0]); bus.src1_data = DW'(p_next[1]);
    bus.fifo_full = full; bus.fifo_empty = empty; bus.fifo_r_en = rd;
    #1;
    exp_data = (m_owner != 0) ? (p_next[x] & 255) : 0;
    check("grant", bus.grant, (m_owner == 1) ? 1 : (m_owner == 2) ? 2 : 0);
    check("w_en", bus.fifo_w_en, ew);
    check("data", bus.fifo_data_in, exp_data);
    check("rdy0", bus.src0_ready, (m_owner == 1) && !m_gap && !full);
    check("rdy1", bus.src1_ready, (m_owner == 2) && !m_gap && !full);
    check("level", bus.fifo_level, m_level);
    check("af", bus.almost_full, m_level >= AF);
    // FIFO contents and transfer log
    rdv = rd && !empty;
    if (rdv) void'(fifo_q.pop_front());
    if (ew) begin
      fifo_q.push_back(exp_data);
      wr_data.push_back(exp_data);
      wr_gnt.push_back(m_owner);
      run_len++;
      p_next[x]++;
      p_left[x]--;
    end else begin
      flush_runs();
    end
    // tracked level, saturating
    if (ew && !rdv) begin
      if (m_level == DEPTH) check("lvl_sat", m_level, DEPTH - 1);
      else m_level++;
    end else if (rdv && !ew) begin
      if (m_level > 0) m_level--;
    end
    // grant rules
    if (m_owner == 0) begin
      if (v[0] && v[1]) m_owner = m_ptr + 1;
      else if (v[0]) m_owner = 1;
      else if (v[1]) m_owner = 2;
      m_words = 0;
    end else if (m_gap) begin
      m_gap = 1'b0;
    end else begin
      if (ew) m_words++;
      by_len = ew && (m_words == BURST);
      if (by_len || !v[x]) begin
        m_words = 0;
        m_ptr = o;
        if (v[o]) m_owner = o + 1;
        else if (by_len) m_gap = 1'b1;
        else m_owner = 0;
      end
    end
  endtask

  initial begin
    int exp_runs [3];
    int start;
    exp_runs[0] = 4; exp_runs[1] = 4; exp_runs[2] = 2;

    // Reset then idle
    model_reset();
    idle_inputs();
    #1 check_reset_outputs();
    #2 rst = 1'b1;
    for (int i = 0; i < 10; i++) cycle();

    // Single producer stream, 10 words
    drive_reset();
    p_on[0] = 1'b1; p_left[0] = 10; p_next[0] = 'h10;
    for (int i = 0; i < 30; i++) cycle();
    flush_runs();
    check("s2_runs_n", runs.size(), 3);
    for (int i = 0; i < 3; i++)
      check("s2_run", (i < runs.size()) ? runs[i] : -1, exp_runs[i]);
    check("s2_words", wr_data.size(), 10);
    for (int i = 0; i < 10; i++)
      check("s2_data", (i < wr_data.size()) ? wr_data[i] : -1, 'h10 + i);
    check("s2_level", bus.fifo_level, 10);
    check("s2_af", bus.almost_full, 0);

    // Contention from reset
    drive_reset();
    p_on[0] = 1'b1; p_on[1] = 1'b1; p_left[0] = 100; p_left[1] = 100;
    p_next[0] = 'h00; p_next[1] = 'h80;
    for (int i = 0; i < 30; i++) cycle();
    flush_runs();
    check("s3_words", wr_data.size(), 16);
    check("s3_runs_n", runs.size(), 1);
    for (int i = 0; i < 16; i++) begin
      check("s3_gnt", (i < wr_gnt.size()) ? wr_gnt[i] : -1, ((i / 4) % 2 == 0) ? 1 : 2);
      check("s3_data", (i < wr_data.size()) ? wr_data[i] : -1,
            (((i / 4) % 2 == 0) ? 0 : 'h80) + (i / 8) * 4 + (i % 4));
    end
    check("s3_level", bus.fifo_level, 16);
    check("s3_af", bus.almost_full, 1);

    // Full stall in the middle of a src1 burst
    drive_reset();
    p_on[1] = 1'b1; p_left[1] = 100; p_next[1] = 'h40;
    p_left[0] = 100; p_next[0] = 'hC0;
    for (int i = 0; i < 10 && wr_data.size() < 2; i++) cycle();
    check("s4_start", wr_data.size(), 2);
    force_full = 1'b1;
    p_on[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("s4_gnt", bus.grant, 2);
      check("s4_rdy1", bus.src1_ready, 0);
      check("s4_wen", bus.fifo_w_en, 0);
    end
    force_full = 1'b0;
    start = wr_data.size();
    for (int i = 0; i < 6; i++) cycle();
    check("s4_more", wr_data.size() >= start + 3, 1);
    if (wr_data.size() >= start + 3) begin
      check("s4_g_a", wr_gnt[start], 2);
      check("s4_g_b", wr_gnt[start + 1], 2);
      check("s4_g_c", wr_gnt[start + 2], 1);
      check("s4_d_a", wr_data[start], 'h42);
      check("s4_d_b", wr_data[start + 1], 'h43);
    end

    // Simultaneous read and write at level 12
    drive_reset();
    p_on[0] = 1'b1; p_left[0] = 12; p_next[0] = 'h00;
    for (int i = 0; i < 25; i++) cycle();
    check("s5_fill", bus.fifo_level, 12);
    check("s5_af_fill", bus.almost_full, 1);
    p_left[0] = 3;
    rd_mode = 3;
    for (int i = 0; i < 10 && wr_data.size() < 15; i++) cycle();
    check("s5_words", wr_data.size(), 15);
    rd_mode = 0;
    cycle();
    check("s5_level", bus.fifo_level, 12);
    check("s5_af", bus.almost_full, 1);
    rd_mode = 1;
    cycle();
    rd_mode = 0;
    cycle();
    check("s5_lvl_rd", bus.fifo_level, 11);
    check("s5_af_rd", bus.almost_full, 0);

    // Asynchronous reset in the middle of a src0 burst
    drive_reset();
    p_on[0] = 1'b1; p_left[0] = 100; p_next[0] = 'h20;
    for (int i = 0; i < 10 && wr_data.size() < 2; i++) cycle();
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("s6_grant", bus.grant, 0);
    check("s6_wen", bus.fifo_w_en, 0);
    check("s6_level", bus.fifo_level, 0);
    model_reset();
    p_on[0] = 1'b1; p_on[1] = 1'b1; p_left[0] = 100; p_left[1] = 100;
    p_next[0] = 'h30; p_next[1] = 'hB0;
    #1 rst = 1'b1;
    for (int i = 0; i < 8; i++) cycle();
    check("s6_first", (wr_gnt.size() > 0) ? wr_gnt[0] : -1, 1);

    // Randomized traffic with random reads
    drive_reset();
    p_on[0] = 1'b1; p_on[1] = 1'b1; p_left[0] = 10000; p_left[1] = 10000;
    p_next[0] = $urandom_range(0, 255); p_next[1] = $urandom_range(0, 255);
    p_rand = 1'b1; rd_mode = 2;
    for (int i = 0; i < 600; i++) cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within 200000 time units");
    $fatal(1);
  end
endmodule
